// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: SPI mode-0 master that streams bytes 0..n_tx of the
// adjacent byte register file out on MOSI. It writes each received byte back
// to the same address, so the transfer is in place and full duplex.
// All outputs are registered; rst is synchronous and active-high.
module spi_master_ctrl #(
  parameter int ADDR_W = 6,
  parameter int DIV    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] n_tx_i,
  input  logic              all_ones_i,
  input  logic              all_zeros_i,
  input  logic [31:0]       rd_data_i,
  output logic              hold_ctrl_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              wr_o,
  output logic [7:0]        wr_data_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [ADDR_W-1:0] rx_count_o,
  output logic              cs_n_o,
  output logic              sclk_o,
  output logic              mosi_o,
  input  logic              miso_i
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_STORE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  // Half-period counter counts 0..DIV-1; keep at least one bit for DIV=1.
  localparam int              DCW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DCW-1:0]  DIV_LAST = DCW'(DIV - 1);

  logic [2:0]        state_q,    state_d;
  logic [ADDR_W-1:0] n_tx_q,     n_tx_d;
  logic              ones_q,     ones_d;
  logic              zeros_q,    zeros_d;
  logic [ADDR_W-1:0] byte_idx_q, byte_idx_d;
  logic [7:0]        tx_shift_q, tx_shift_d;
  logic [7:0]        rx_shift_q, rx_shift_d;
  logic [2:0]        bit_cnt_q,  bit_cnt_d;
  logic [DCW-1:0]    div_cnt_q,  div_cnt_d;
  logic              hold_q,     hold_d;
  logic [ADDR_W-1:0] addr_q,     addr_d;
  logic              wr_q,       wr_d;
  logic [7:0]        wr_data_q,  wr_data_d;
  logic              busy_q,     busy_d;
  logic              done_q,     done_d;
  logic [ADDR_W-1:0] rx_count_q, rx_count_d;
  logic              cs_n_q,     cs_n_d;
  logic              sclk_q,     sclk_d;
  logic              mosi_q,     mosi_d;
  logic [7:0]        tx_byte_s;

  // Only the low byte of the register-file read bus carries data.
  logic unused_rd_s;
  assign unused_rd_s = ^rd_data_i[31:8];

  // Next-state logic: sequence IDLE -> (LOAD -> SHIFT -> STORE)* -> DONE.
  always_comb begin
    state_d    = state_q;
    n_tx_d     = n_tx_q;
    ones_d     = ones_q;
    zeros_d    = zeros_q;
    byte_idx_d = byte_idx_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    bit_cnt_d  = bit_cnt_q;
    div_cnt_d  = div_cnt_q;
    hold_d     = hold_q;
    addr_d     = addr_q;
    wr_d       = 1'b0;
    wr_data_d  = wr_data_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    rx_count_d = rx_count_q;
    cs_n_d     = cs_n_q;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    tx_byte_s  = 8'h00;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          n_tx_d     = n_tx_i;
          ones_d     = all_ones_i;
          zeros_d    = all_zeros_i;
          byte_idx_d = '0;
          rx_count_d = '0;
          addr_d     = '0;
          busy_d     = 1'b1;
          hold_d     = 1'b1;
          state_d    = S_LOAD;
        end else begin
          state_d    = S_IDLE;
        end
      end
      S_LOAD: begin
        // addr already points at byte_idx, so rd_data is valid this cycle.
        if (ones_q) begin
          tx_byte_s = 8'hFF;
        end else if (zeros_q) begin
          tx_byte_s = 8'h00;
        end else begin
          tx_byte_s = rd_data_i[7:0];
        end
        tx_shift_d = tx_byte_s;
        mosi_d     = tx_byte_s[7];
        cs_n_d     = 1'b0;
        sclk_d     = 1'b0;
        bit_cnt_d  = 3'd0;
        div_cnt_d  = '0;
        state_d    = S_SHIFT;
      end
      S_SHIFT: begin
        if (div_cnt_q == DIV_LAST) begin
          div_cnt_d = '0;
          sclk_d    = ~sclk_q;
          if (!sclk_q) begin
            // Rising SCLK: sample MISO.
            rx_shift_d = {rx_shift_q[6:0], miso_i};
          end else if (bit_cnt_q == 3'd7) begin
            // Falling SCLK after the last bit: present the byte for write-back.
            wr_d      = 1'b1;
            addr_d    = byte_idx_q;
            wr_data_d = rx_shift_q;
            state_d   = S_STORE;
          end else begin
            // Falling SCLK: advance MOSI to the next bit.
            bit_cnt_d  = bit_cnt_q + 3'd1;
            tx_shift_d = {tx_shift_q[6:0], 1'b0};
            mosi_d     = tx_shift_q[6];
          end
        end else begin
          div_cnt_d = div_cnt_q + DCW'(1);
        end
      end
      S_STORE: begin
        rx_count_d = rx_count_q + ADDR_W'(1);
        // Compare before incrementing so n_tx = all-ones never wraps.
        if (byte_idx_q == n_tx_q) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          hold_d  = 1'b0;
          cs_n_d  = 1'b1;
          mosi_d  = 1'b0;
          state_d = S_DONE;
        end else begin
          byte_idx_d = byte_idx_q + ADDR_W'(1);
          addr_d     = byte_idx_q + ADDR_W'(1);
          state_d    = S_LOAD;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; rst forces the idle/reset values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      n_tx_q     <= '0;
      ones_q     <= 1'b0;
      zeros_q    <= 1'b0;
      byte_idx_q <= '0;
      tx_shift_q <= 8'h00;
      rx_shift_q <= 8'h00;
      bit_cnt_q  <= 3'd0;
      div_cnt_q  <= '0;
      hold_q     <= 1'b0;
      addr_q     <= '0;
      wr_q       <= 1'b0;
      wr_data_q  <= 8'h00;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rx_count_q <= '0;
      cs_n_q     <= 1'b1;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_tx_q     <= n_tx_d;
      ones_q     <= ones_d;
      zeros_q    <= zeros_d;
      byte_idx_q <= byte_idx_d;
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      bit_cnt_q  <= bit_cnt_d;
      div_cnt_q  <= div_cnt_d;
      hold_q     <= hold_d;
      addr_q     <= addr_d;
      wr_q       <= wr_d;
      wr_data_q  <= wr_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rx_count_q <= rx_count_d;
      cs_n_q     <= cs_n_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
    end
  end

  assign hold_ctrl_o = hold_q;
  assign addr_o      = addr_q;
  assign wr_o        = wr_q;
  assign wr_data_o   = wr_data_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign rx_count_o  = rx_count_q;
  assign cs_n_o      = cs_n_q;
  assign sclk_o      = sclk_q;
  assign mosi_o      = mosi_q;

endmodule

// File: doc/spi_master_ctrl.md
# spi_master_ctrl

SPI master controller that sits directly next to the byte register file. On `start` it takes ownership of the register file by asserting `hold_ctrl`. It then transmits `n_tx+1` bytes read from addresses 0..n_tx MSB-first over SPI mode 0 (CPOL=0, CPHA=0), and writes each simultaneously received byte back to the same address through the file's second write port. The transfer is full-duplex and in place.

## Interface
Parameters:
- `ADDR_W`, 6, width of register-file address and byte counters.
- `DIV`, 4, SCLK half-period in `clk` cycles; legal range is ≥1.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  begin transaction; sampled only in IDLE.
- `n_tx`  in  ADDR_W  index of last byte; transfers n_tx+1 bytes.
- `all_ones`  in  1  transmit 0xFF instead of memory data.
- `all_zeros`  in  1  transmit 0x00 instead of memory data; `all_ones` has priority.
- `rd_data`  in  32  combinational read data from register file at `addr`; bits [7:0] used.
- `hold_ctrl`  out  1  high while transaction active; register file then uses `addr`.
- `addr`  out  ADDR_W  register-file address (read and write).
- `wr`  out  1  one-cycle write strobe to register file.
- `wr_data`  out  8  received byte.
- `busy`  out  1  transaction in progress.
- `done`  out  1  one-cycle pulse at end of transaction.
- `rx_count`  out  ADDR_W  bytes stored in current/last transaction.
- `cs_n`  out  1  chip select, active low.
- `sclk`  out  1  SPI clock.
- `mosi`  out  1  serial data out.
- `miso`  in  1  serial data in.

## Operation
- All outputs are registered.
- Reset values: `cs_n`=1; `sclk`, `mosi`, `hold_ctrl`, `wr`, `busy` and `done`=0; `wr_data`, `addr` and `rx_count`=0.
- State encoding is IDLE, LOAD, SHIFT, STORE, DONE.
- **IDLE**:
  - `start`=1 latches `n_tx`, `all_ones` and `all_zeros`.
  - Sets byte_idx=0 and rx_count=0, raises `busy` and `hold_ctrl`, then goes to LOAD.
- **LOAD** (1 cycle):
  - `addr`=byte_idx.
  - tx_shift ← 0xFF if all_ones, else 0x00 if all_zeros, else `rd_data[7:0]`.
  - `cs_n`←0, `mosi`←tx bit 7, bit_cnt←0, go to SHIFT.
- **SHIFT**:
  - Each bit is DIV cycles with `sclk`=0, then DIV cycles with `sclk`=1.
  - On the edge where `sclk` goes 0→1: rx_shift ← {rx_shift[6:0], `miso`}.
  - On the edge where `sclk` goes 1→0 after bits 0..6: `mosi` ← next bit.
  - After bit 7's high phase `sclk` returns to 0 and the state goes to STORE.
- **STORE** (1 cycle):
  - `wr`=1, `addr`=byte_idx, `wr_data`=rx byte, rx_count+1.
  - If byte_idx==n_tx, go to DONE; else byte_idx+1 and go to LOAD.
- **DONE** (1 cycle): `cs_n`←1, `done`=1, `busy` and `hold_ctrl` drop, go to IDLE.
- `cs_n` stays low across byte boundaries within a transaction.
- Ignored inputs:
  - `start` is ignored outside IDLE.
  - `n_tx`, `all_ones` and `all_zeros` changes mid-transaction are ignored.
- n_tx = 2^ADDR_W−1 is legal: the whole file is transferred and byte_idx does not wrap before DONE.
- `rst` mid-transaction: outputs return to reset values on that edge, no `wr` is issued, and the state goes to IDLE.
- `rx_count` holds its value after DONE until the next accepted `start`.

## Timing
- Cycle 0 is the edge at which `start` is sampled.
- Byte k (from 0) occupies 16·DIV+2 cycles:
  - LOAD in cycle k(16·DIV+2)+1.
  - SHIFT for 16·DIV cycles.
  - STORE in the cycle after SHIFT.
- `done` is high in cycle (n_tx+1)(16·DIV+2)+1. For DIV=4 with one byte, that is cycle 67.
- `start` is accepted again the cycle after DONE.
- SCLK period is 2·DIV cycles. First rising `sclk` is DIV cycles after `cs_n` falls.
- MOSI is stable ≥DIV cycles before each rising edge.

## Test plan
- Reset: assert `rst` 2 cycles mid-idle -> `cs_n`=1, `sclk`=0, `mosi`=0, `hold_ctrl`=0, `wr`=0, `busy`=0, `rx_count`=0.
- Single-byte loopback (`miso`=`mosi`, DIV=4): mem[0]=0xA5, n_tx=0, pulse `start` -> MOSI bits 1,0,1,0,0,1,0,1 on rising edges; `wr` at addr 0 with 0xA5; `done` in cycle 67; `rx_count`=1.
- Multi-byte: mem[0..2]=0x11,0x22,0x33, n_tx=2, `miso`=0 -> MOSI shows 0x11, 0x22, 0x33; three `wr` pulses addr 0,1,2 with data 0x00; `cs_n` low continuously; `rx_count`=3.
- Fill priority: `all_ones`=`all_zeros`=1, `miso`=1, mem[0]=0x00 -> `mosi` constant 1, `wr_data`=0xFF; then `all_ones`=0 -> `mosi` constant 0.
- Disturbance:
  - `start` re-pulsed while `busy` -> no restart, timing unchanged.
  - `rst` during bit 3 -> `cs_n`=1 next cycle, no `wr`.
  - A subsequent `start` completes normally.
- DIV=1: n_tx=0 -> `sclk` toggles every cycle, `done` in cycle 19.
